// File: rtl/register_file_if.sv
// Request/address/data bundle between the core datapath and the register file.
// The master raises request strobes; the slave returns held read data.
interface register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  req_ra_i;
  logic                  req_rb_i;
  logic                  req_w_i;
  logic [ADDR_WIDTH-1:0] raddr_a_i;
  logic [DATA_WIDTH-1:0] rdata_a_o;
  logic [ADDR_WIDTH-1:0] raddr_b_i;
  logic [DATA_WIDTH-1:0] rdata_b_o;
  logic [ADDR_WIDTH-1:0] waddr_a_i;
  logic [DATA_WIDTH-1:0] wdata_a_i;

  modport master (
    output req_ra_i, req_rb_i, req_w_i,
    output raddr_a_i, raddr_b_i, waddr_a_i, wdata_a_i,
    input  rdata_a_o, rdata_b_o
  );

  modport slave (
    input  req_ra_i, req_rb_i, req_w_i,
    input  raddr_a_i, raddr_b_i, waddr_a_i, wdata_a_i,
    output rdata_a_o, rdata_b_o
  );
endinterface

// File: rtl/register_file.sv
// 32 x 32 RV32I register file, two read ports and one write port.
// Every port acts only on the rising edge of its request strobe; read data is held until the next read.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  register_file_if.slave bus
);
  localparam int NREGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NREGS];
  logic [DATA_WIDTH-1:0] regs_d [NREGS];
  logic [DATA_WIDTH-1:0] rdata_a_q, rdata_a_d;
  logic [DATA_WIDTH-1:0] rdata_b_q, rdata_b_d;
  logic                  req_ra_q, req_ra_d;
  logic                  req_rb_q, req_rb_d;
  logic                  req_w_q, req_w_d;
  logic                  fire_ra, fire_rb, fire_w;

  // Only a definite 1 counts as asserted, so an X strobe cannot fire a port.
  always_comb begin
    fire_ra = (bus.req_ra_i == 1'b1) && !req_ra_q;
    fire_rb = (bus.req_rb_i == 1'b1) && !req_rb_q;
    fire_w  = (bus.req_w_i  == 1'b1) && !req_w_q;
  end

  always_comb begin
    req_ra_d  = (bus.req_ra_i == 1'b1);
    req_rb_d  = (bus.req_rb_i == 1'b1);
    req_w_d   = (bus.req_w_i  == 1'b1);
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
    regs_d    = regs_q;
    // Reads sample the pre-write array, so a same-edge read/write returns the old value.
    if (fire_ra) rdata_a_d = regs_q[bus.raddr_a_i];
    if (fire_rb) rdata_b_d = regs_q[bus.raddr_b_i];
    if (fire_w && (bus.waddr_a_i != '0)) regs_d[bus.waddr_a_i] = bus.wdata_a_i;
    regs_d[0] = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
      req_ra_q  <= 1'b0;
      req_rb_q  <= 1'b0;
      req_w_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
      req_ra_q  <= req_ra_d;
      req_rb_q  <= req_rb_d;
      req_w_q   <= req_w_d;
    end
  end

  assign bus.rdata_a_o = rdata_a_q;
  assign bus.rdata_b_o = rdata_b_q;
endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed walk through the main scenarios, then random strobes
// checked against an array model of the register contents and held read data.
module tb_register_file;
  logic clk_i;
  logic rst_ni;
  int   checks;
  int   errors;

  register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [31:0] mdl [32];
  logic [31:0] exp_a, exp_b;
  logic        prev_ra, prev_rb, prev_w;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    exp_a   = 32'h0;
    exp_b   = 32'h0;
    prev_ra = 1'b0;
    prev_rb = 1'b0;
    prev_w  = 1'b0;
  endtask

  // Called with inputs already set (clock low); advances one edge and checks both read ports.
  task automatic step();
    logic fa, fb, fw;
    fa = bus.req_ra_i && !prev_ra;
    fb = bus.req_rb_i && !prev_rb;
    fw = bus.req_w_i  && !prev_w;
    if (fa) exp_a = mdl[bus.raddr_a_i];
    if (fb) exp_b = mdl[bus.raddr_b_i];
    if (fw && bus.waddr_a_i != 5'd0) mdl[bus.waddr_a_i] = bus.wdata_a_i;
    prev_ra = bus.req_ra_i;
    prev_rb = bus.req_rb_i;
    prev_w  = bus.req_w_i;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("model_rdata_a", bus.rdata_a_o, exp_a);
    chk("model_rdata_b", bus.rdata_b_o, exp_b);
  endtask

  task automatic drive(input logic ra, input logic rb, input logic w,
                       input logic [4:0] aa, input logic [4:0] ab, input logic [4:0] aw,
                       input logic [31:0] wd);
    bus.req_ra_i  = ra;
    bus.req_rb_i  = rb;
    bus.req_w_i   = w;
    bus.raddr_a_i = aa;
    bus.raddr_b_i = ab;
    bus.waddr_a_i = aw;
    bus.wdata_a_i = wd;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_ni = 1'b0;
    bus.req_ra_i = 1'b0; bus.req_rb_i = 1'b0; bus.req_w_i = 1'b0;
    bus.raddr_a_i = '0; bus.raddr_b_i = '0; bus.waddr_a_i = '0; bus.wdata_a_i = '0;
    model_reset();
    repeat (2) @(negedge clk_i);
    chk("reset_rdata_a", bus.rdata_a_o, 32'h0);
    chk("reset_rdata_b", bus.rdata_b_o, 32'h0);
    rst_ni = 1'b1;

    // write then dual read
    drive(0, 0, 1, 0, 0, 5'd4, 32'h0000_0001);
    drive(0, 0, 0, 0, 0, 5'd4, 32'h0000_0001);
    drive(0, 0, 1, 0, 0, 5'd2, 32'h000C_0001);
    drive(0, 0, 0, 0, 0, 5'd2, 32'h000C_0001);
    drive(1, 1, 0, 5'd4, 5'd2, 0, 0);
    chk("dual_read_a", bus.rdata_a_o, 32'h0000_0001);
    chk("dual_read_b", bus.rdata_b_o, 32'h000C_0001);

    // held request ignores address change until re-armed
    drive(1, 0, 0, 5'd2, 5'd2, 0, 0);
    chk("hold_a", bus.rdata_a_o, 32'h0000_0001);
    drive(0, 0, 0, 5'd2, 5'd2, 0, 0);
    drive(1, 0, 0, 5'd2, 5'd2, 0, 0);
    chk("rearm_a", bus.rdata_a_o, 32'h000C_0001);

    // x0 write ignored
    drive(0, 0, 1, 5'd2, 5'd2, 5'd0, 32'hDEAD_BEEF);
    drive(0, 0, 0, 5'd2, 5'd2, 5'd0, 32'hDEAD_BEEF);
    drive(1, 1, 0, 5'd0, 5'd0, 0, 0);
    chk("x0_read_a", bus.rdata_a_o, 32'h0);
    chk("x0_read_b", bus.rdata_b_o, 32'h0);

    // same-edge read and write
    drive(0, 0, 1, 5'd5, 0, 5'd5, 32'h1111_1111);
    drive(0, 0, 0, 5'd5, 0, 5'd5, 32'h1111_1111);
    drive(1, 0, 1, 5'd5, 0, 5'd5, 32'h2222_2222);
    chk("same_edge_old", bus.rdata_a_o, 32'h1111_1111);
    drive(0, 0, 0, 5'd5, 0, 5'd5, 32'h2222_2222);
    drive(1, 0, 0, 5'd5, 0, 0, 0);
    chk("same_edge_new", bus.rdata_a_o, 32'h2222_2222);

    // held write request writes only the first-edge value
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 5'd5, 0, 5'd7, 32'hA + i);
    drive(0, 0, 0, 5'd5, 0, 5'd7, 32'hF);
    drive(1, 0, 0, 5'd7, 0, 0, 0);
    chk("held_write_x7", bus.rdata_a_o, 32'h0000_000A);

    // asynchronous reset while the clock is low
    bus.req_ra_i = 1'b0; bus.req_rb_i = 1'b0; bus.req_w_i = 1'b0;
    #1 rst_ni = 1'b0;
    #1;
    chk("async_rst_a", bus.rdata_a_o, 32'h0);
    chk("async_rst_b", bus.rdata_b_o, 32'h0);
    model_reset();
    #1 rst_ni = 1'b1;
    drive(1, 0, 0, 5'd4, 0, 0, 0);
    chk("post_rst_x4", bus.rdata_a_o, 32'h0);
    drive(0, 0, 0, 5'd4, 0, 0, 0);

    // request already high at the first edge after reset fires
    drive(0, 0, 1, 0, 0, 5'd9, 32'h1234_5678);
    drive(0, 0, 0, 0, 0, 5'd9, 0);
    bus.req_ra_i = 1'b1; bus.raddr_a_i = 5'd9;
    rst_ni = 1'b0;
    model_reset();
    #1 rst_ni = 1'b1;
    drive(1, 0, 0, 5'd9, 0, 0, 0);
    chk("first_edge_fire", bus.rdata_a_o, 32'h0);

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            $urandom);
    end
    for (int r = 0; r < 32; r++) begin
      drive(0, 0, 0, 5'(r), 5'(31 - r), 0, 0);
      drive(1, 1, 0, 5'(r), 5'(31 - r), 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
